// File: rtl/notes_scroller_if.sv
// Lane control and note-field bus between the game controller and the scroller.
// The controller is master; the scroller is slave.
interface notes_scroller_if;
    logic [1:0]   state;
    logic [6:0]   spawn;
    logic [6:0]   btn;
    logic [191:0] notesMap0;
    logic [191:0] notesMap1;
    logic [191:0] notesMap2;
    logic [191:0] notesMap3;
    logic [191:0] notesMap4;
    logic [191:0] notesMap5;
    logic [191:0] notesMap6;
    logic [6:0]   hit;
    logic [6:0]   miss;
    logic         step;

    modport master (
        output state, spawn, btn,
        input  notesMap0, notesMap1, notesMap2, notesMap3,
        input  notesMap4, notesMap5, notesMap6,
        input  hit, miss, step
    );

    modport slave (
        input  state, spawn, btn,
        output notesMap0, notesMap1, notesMap2, notesMap3,
        output notesMap4, notesMap5, notesMap6,
        output hit, miss, step
    );
endinterface

// File: rtl/notes_scroller.sv
// Seven-lane falling-note field: scrolls notes toward the hit line,
// judges presses against the hit window and reports hits and misses.
module notes_scroller #(
    parameter int          STEP_DIV = 2_000_000,
    parameter int          HIT_LO   = 5,
    parameter int          HIT_HI   = 7,
    parameter logic [2:0]  NOTE_RGB = 3'b011
) (
    input logic            clk,
    input logic            rst,
    notes_scroller_if.slave bus
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    function automatic logic [63:0] winMask();
        logic [63:0] m;
        m = '0;
        for (int c = 0; c < 64; c++) begin
            m[c] = (c >= HIT_LO) && (c <= HIT_HI);
        end
        return m;
    endfunction

    localparam logic [63:0] WIN = winMask();

    logic [63:0]   occ [7];
    logic [6:0]    pend;
    logic [CW-1:0] cnt;
    logic [6:0]    hitR;
    logic [6:0]    missR;
    logic          stepR;

    logic          play;
    logic          stepNow;
    logic [63:0]   win      [7];
    logic [63:0]   lowBit   [7];
    logic [63:0]   afterHit [7];
    logic [6:0]    hitNext;
    logic [6:0]    missNext;
    logic [191:0]  map      [7];

    // Hits are removed before the shift so a same-cycle press sees pre-shift columns.
    always_comb begin
        play     = (bus.state == 2'd2);
        stepNow  = play && (cnt == LAST);
        hitNext  = '0;
        missNext = '0;
        for (int k = 0; k < 7; k++) begin
            win[k]      = occ[k] & WIN;
            lowBit[k]   = win[k] & (~win[k] + 64'd1);
            hitNext[k]  = play && bus.btn[k] && (|win[k]);
            afterHit[k] = hitNext[k] ? (occ[k] & ~lowBit[k]) : occ[k];
            missNext[k] = stepNow && afterHit[k][0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 7; k++) occ[k] <= '0;
            pend  <= '0;
            cnt   <= '0;
            hitR  <= '0;
            missR <= '0;
            stepR <= 1'b0;
        end else if (!play) begin
            for (int k = 0; k < 7; k++) occ[k] <= '0;
            pend  <= '0;
            cnt   <= '0;
            hitR  <= '0;
            missR <= '0;
            stepR <= 1'b0;
        end else begin
            for (int k = 0; k < 7; k++) begin
                if (stepNow)
                    occ[k] <= {pend[k] | bus.spawn[k], afterHit[k][63:1]};
                else
                    occ[k] <= afterHit[k];
            end
            pend  <= stepNow ? 7'd0 : (pend | bus.spawn);
            cnt   <= stepNow ? '0 : cnt + 1'b1;
            hitR  <= hitNext;
            missR <= missNext;
            stepR <= stepNow;
        end
    end

    always_comb begin
        for (int k = 0; k < 7; k++) begin
            map[k] = '0;
            for (int c = 0; c < 64; c++) begin
                map[k][3*c +: 3] = occ[k][c] ? NOTE_RGB : 3'b000;
            end
        end
    end

    assign bus.notesMap0 = map[0];
    assign bus.notesMap1 = map[1];
    assign bus.notesMap2 = map[2];
    assign bus.notesMap3 = map[3];
    assign bus.notesMap4 = map[4];
    assign bus.notesMap5 = map[5];
    assign bus.notesMap6 = map[6];
    assign bus.hit       = hitR;
    assign bus.miss      = missR;
    assign bus.step      = stepR;

endmodule
